// File: rtl/serial_add16_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The master side drives the operands, the slave side is the adder.
interface serial_add16_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, sum, cout, ovf, zero, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, sum, cout, ovf, zero, out_valid
  );
endinterface

// File: rtl/serial_add16.sv
// Bit-serial adder: one operand bit pair per cycle, LSB first.
// Flow: IDLE accepts operands, RUN takes WIDTH cycles, DONE holds the result.
module serial_add16 #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_add16_if.slave bus
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_maj;
  logic             w_last;

  assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_maj  = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_last = (r_cnt == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) w_state_next = S_RUN;
        else              w_state_next = S_IDLE;
      end
      S_RUN: begin
        if (w_last) w_state_next = S_DONE;
        else        w_state_next = S_RUN;
      end
      S_DONE: begin
        if (bus.out_ready) w_state_next = S_IDLE;
        else               w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand shifters, carry chain, counter and result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_carry <= w_maj;
          r_cnt   <= r_cnt + CW'(1);
          // On the MSB cycle r_carry is the carry into bit WIDTH-1.
          if (w_last) begin
            r_cout <= w_maj;
            r_ovf  <= r_carry ^ w_maj;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = (r_state == S_DONE) && (r_sum == '0);

endmodule

// File: tb/tb_serial_add16.sv
// Directed and random checks of serial_add16 against an arithmetic model,
// using a result scoreboard filled at operand drive time.
module tb_serial_add16;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  serial_add16_if #(.WIDTH(W)) bus ();
  serial_add16 #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  res_t sb[$];

  function automatic res_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    res_t     r;
    logic [W:0] t;
    t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    r.zero = (t[W-1:0] == {W{1'b0}});
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, output res_t e);
    e = '0;
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_sum"},  32'(bus.sum),  32'(e.sum));
      check({tag, "_cout"}, 32'(bus.cout), 32'(e.cout));
      check({tag, "_ovf"},  32'(bus.ovf),  32'(e.ovf));
      check({tag, "_zero"}, 32'(bus.zero), 32'(e.zero));
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bus.a   = a;
    bus.b   = b;
    bus.cin = c;
    sb.push_back(ref_add(a, b, c));
  endtask

  // Operands are scrambled after capture to show they are not re-sampled.
  task automatic wait_valid(output int lat, input bit drop_valid);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if (drop_valid) bus.in_valid = 1'b0;
        bus.a   = W'($urandom());
        bus.b   = W'($urandom());
        bus.cin = ~bus.cin;
      end
    end while (!bus.out_valid && lat < 200);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int   lat;
    res_t e;
    drive(a, b, c);
    bus.in_valid = 1'b1;
    wait_valid(lat, 1'b1);
    check({tag, "_latency"}, 32'(lat), 32'(W + 1));
    check_result(tag, e);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_out_valid_after"}, 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   lat;
    int   prev;
    bit   seen;
    res_t e;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum",       32'(bus.sum),       32'd0);
    check("rst_cout",      32'(bus.cout),      32'd0);
    check("rst_ovf",       32'(bus.ovf),       32'd0);
    check("rst_zero",      32'(bus.zero),      32'd0);

    // Release and accept on the very first rising edge with rst_n high.
    rst_n = 1'b1;
    run_op("add_3_5",      16'h0003, 16'h0005, 1'b0);
    run_op("add_ffff_1",   16'hFFFF, 16'h0001, 1'b0);
    run_op("add_7fff_c",   16'h7FFF, 16'h0000, 1'b1);
    run_op("add_8000_8000",16'h8000, 16'h8000, 1'b0);
    run_op("add_ffff_ffff",16'hFFFF, 16'hFFFF, 1'b1);

    // Backpressure in DONE with ignored in_valid pulses.
    drive(16'h1234, 16'hEDCB, 1'b1);
    bus.in_valid = 1'b1;
    wait_valid(lat, 1'b1);
    check("bp_latency", 32'(lat), 32'(W + 1));
    check_result("bp", e);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.a        = W'($urandom());
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      check("bp_sum",       32'(bus.sum),       32'(e.sum));
      check("bp_cout",      32'(bus.cout),      32'(e.cout));
      check("bp_ovf",       32'(bus.ovf),       32'(e.ovf));
      check("bp_zero",      32'(bus.zero),      32'(e.zero));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp_stay_idle", 32'(bus.in_ready), 32'd1);

    // Reset at RUN cycle 7 abandons the operation.
    bus.a        = 16'h00FF;
    bus.b        = 16'h0F0F;
    bus.cin      = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_run_busy", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("mid_rst_sum",       32'(bus.sum),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("no_result_after_rst", 32'(seen), 32'd0);
    run_op("after_rst", 16'hA5A5, 16'h5A5B, 1'b0);

    // Back-to-back random operations with in_valid and out_ready held high.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    prev          = 0;
    for (int i = 0; i < 1000; i++) begin
      lat = 0;
      while (!bus.in_ready && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      check("b2b_ready_wait", 32'(bus.in_ready), 32'd1);
      drive(W'($urandom()), W'($urandom()), 1'($urandom_range(1, 0)));
      wait_valid(lat, 1'b0);
      check("b2b_latency", 32'(lat), 32'(W + 1));
      if (i > 0) check("b2b_period", 32'(cyc - prev), 32'(W + 2));
      prev = cyc;
      check_result("b2b", e);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
